// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_DMEM_WAIT,
    CTRL_TRAP
  } ctrl_state_e;

  // Which rule won the priority decode this cycle; it also drives the
  // output decode, so it stays visible as a debug signal.
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_FREEZE,
    HZ_REDIRECT,
    HZ_LOAD_USE,
    HZ_IMEM_WAIT
  } hazard_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load result is needed by ID only if the source is really read and
  // the destination is not x0 (writes to x0 are discarded).
  function automatic logic reg_hit(logic [4:0] rd, logic [4:0] rs, logic used);
    return used && (rd == rs) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the pipeline and stage control outputs back to it.
// Latency: n/a (wiring only).
// Backpressure: n/a; the controller answers combinationally every cycle.
// master = pipeline side (drives hazard status, receives controls)
// slave  = controller side
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       if_id_rs1_i;
  logic [4:0]       if_id_rs2_i;
  logic             if_id_rs1_used_i;
  logic             if_id_rs2_used_i;
  logic             id_ex_memread_i;
  logic [4:0]       id_ex_rd_i;
  logic             ex_redirect_i;
  logic             imem_ready_i;
  logic             ex_mem_memreq_i;
  logic             dmem_ready_i;
  logic             pc_en_o;
  logic             pc_sel_redirect_o;
  logic             if_id_en_o;
  logic             if_id_flush_o;
  logic             id_ex_en_o;
  logic             id_ex_flush_o;
  logic             ex_mem_en_o;
  logic             mem_wb_en_o;
  logic             mem_wb_flush_o;
  logic             dmem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output if_id_rs1_i, if_id_rs2_i, if_id_rs1_used_i, if_id_rs2_used_i,
           id_ex_memread_i, id_ex_rd_i, ex_redirect_i, imem_ready_i,
           ex_mem_memreq_i, dmem_ready_i,
    input  pc_en_o, pc_sel_redirect_o, if_id_en_o, if_id_flush_o,
           id_ex_en_o, id_ex_flush_o, ex_mem_en_o, mem_wb_en_o,
           mem_wb_flush_o, dmem_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  if_id_rs1_i, if_id_rs2_i, if_id_rs1_used_i, if_id_rs2_used_i,
           id_ex_memread_i, id_ex_rd_i, ex_redirect_i, imem_ready_i,
           ex_mem_memreq_i, dmem_ready_i,
    output pc_en_o, pc_sel_redirect_o, if_id_en_o, if_id_flush_o,
           id_ex_en_o, id_ex_flush_o, ex_mem_en_o, mem_wb_en_o,
           mem_wb_flush_o, dmem_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_controller_perf_counter.sv
// Free-running event counter, wraps modulo 2^CNT_W.
// Latency: cnt_o reflects an inc_i one clock after it is seen.
// Backpressure: none; counts every cycle inc_i is high.
// Ports: clk_i, rst_ni (async active-low), inc_i, cnt_o.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stage enables, flushes and PC select for a 5-stage RV32I pipeline.
// Latency: controls are combinational from state and inputs (same cycle).
// Backpressure: a data-memory wait freezes every stage; imem/load-use stall the front end.
// Ports: clk_i, rst_ni (async active-low), hz (slave modport: hazard inputs,
// stage enables/flushes, PC select, sticky timeout trap, stall/flush counters).
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 255,  // legal range 1 .. 2^TO_W-1
  parameter int TO_W         = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  pipeline_hazard_controller_if.slave   hz
);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_nxt;
  logic [TO_W-1:0] r_wd;
  logic [TO_W-1:0] w_wd_nxt;
  logic [TO_W-1:0] w_wd_inc;
  logic            r_timeout;
  logic            w_frozen;
  logic            w_load_use;
  hazard_e         w_hazard;

  // Hazard classification, highest priority first.
  always_comb begin
    w_load_use = hz.id_ex_memread_i &&
                 (reg_hit(hz.id_ex_rd_i, hz.if_id_rs1_i, hz.if_id_rs1_used_i) ||
                  reg_hit(hz.id_ex_rd_i, hz.if_id_rs2_i, hz.if_id_rs2_used_i));

    w_frozen = 1'b0;
    case (r_state)
      CTRL_TRAP:      w_frozen = 1'b1;
      // The access that caused the wait is held in EX/MEM, so only ready matters.
      CTRL_DMEM_WAIT: w_frozen = !hz.dmem_ready_i;
      default:        w_frozen = hz.ex_mem_memreq_i && !hz.dmem_ready_i;
    endcase

    w_hazard = HZ_NONE;
    // Reset output values coincide with a freeze, so reset shares that decode.
    if (!rst_ni || w_frozen)       w_hazard = HZ_FREEZE;
    else if (hz.ex_redirect_i)     w_hazard = HZ_REDIRECT;
    else if (w_load_use)           w_hazard = HZ_LOAD_USE;
    else if (!hz.imem_ready_i)     w_hazard = HZ_IMEM_WAIT;
  end

  always_comb begin
    hz.pc_en_o           = 1'b1;
    hz.pc_sel_redirect_o = 1'b0;
    hz.if_id_en_o        = 1'b1;
    hz.if_id_flush_o     = 1'b0;
    hz.id_ex_en_o        = 1'b1;
    hz.id_ex_flush_o     = 1'b0;
    hz.ex_mem_en_o       = 1'b1;
    hz.mem_wb_en_o       = 1'b1;
    case (w_hazard)
      HZ_FREEZE: begin
        hz.pc_en_o     = 1'b0;
        hz.if_id_en_o  = 1'b0;
        hz.id_ex_en_o  = 1'b0;
        hz.ex_mem_en_o = 1'b0;
        hz.mem_wb_en_o = 1'b0;
      end
      HZ_REDIRECT: begin
        hz.pc_sel_redirect_o = 1'b1;
        hz.if_id_flush_o     = 1'b1;
        hz.id_ex_flush_o     = 1'b1;
      end
      HZ_LOAD_USE: begin
        // One bubble; it clears id_ex_memread_i so the stall ends by itself.
        hz.pc_en_o       = 1'b0;
        hz.if_id_en_o    = 1'b0;
        hz.id_ex_flush_o = 1'b1;
      end
      HZ_IMEM_WAIT: begin
        hz.pc_en_o       = 1'b0;
        hz.if_id_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes with no writeback would need a MEM/WB bubble; not used, port reserved.
  assign hz.mem_wb_flush_o = 1'b0;
  assign hz.dmem_timeout_o = r_timeout;

  // Watchdog holds the number of frozen wait cycles seen so far in this access.
  always_comb begin
    w_state_nxt = r_state;
    w_wd_nxt    = r_wd;
    w_wd_inc    = r_wd + TO_W'(1);
    case (r_state)
      CTRL_RUN: begin
        if (hz.ex_mem_memreq_i && !hz.dmem_ready_i) begin
          w_wd_nxt    = TO_W'(1);
          w_state_nxt = (DMEM_TIMEOUT == 1) ? CTRL_TRAP : CTRL_DMEM_WAIT;
        end
      end
      CTRL_DMEM_WAIT: begin
        if (hz.dmem_ready_i) begin
          w_wd_nxt    = '0;
          w_state_nxt = CTRL_RUN;
        end else begin
          w_wd_nxt = w_wd_inc;
          if (w_wd_inc == TO_W'(DMEM_TIMEOUT)) w_state_nxt = CTRL_TRAP;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= CTRL_RUN;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wd      <= w_wd_nxt;
      r_timeout <= r_timeout || (w_state_nxt == CTRL_TRAP);
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (!hz.pc_en_o),
    .cnt_o  (hz.stall_cnt_o)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (hz.pc_sel_redirect_o),
    .cnt_o  (hz.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: the stimulus process computes expected controls from a
// behavioural model and queues them; a monitor compares on every falling edge.
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 32;
  localparam int TO    = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  pipeline_hazard_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hz     (bus)
  );

  // ctl = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //        ex_mem_en, mem_wb_en, mem_wb_flush}
  typedef struct packed {
    logic [8:0]       ctl;
    logic             to;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: trapped flag, count of frozen memory-wait cycles, counters.
  bit               m_trap = 0, n_trap = 0;
  int               m_wait = 0, n_wait = 0;
  logic [CNT_W-1:0] m_stall = '0, n_stall = '0;
  logic [CNT_W-1:0] m_flush = '0, n_flush = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] act_ctl();
    return {bus.pc_en_o, bus.pc_sel_redirect_o, bus.if_id_en_o, bus.if_id_flush_o,
            bus.id_ex_en_o, bus.id_ex_flush_o, bus.ex_mem_en_o, bus.mem_wb_en_o,
            bus.mem_wb_flush_o};
  endfunction

  task automatic cycle(input bit rst, input bit memreq, input bit dready, input bit iready,
                       input bit redir, input bit memread, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2);
    exp_t e;
    bit prev_rst, frozen, lu;
    bit pc_en, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en;
    @(posedge clk_i);
    #1;
    m_trap = n_trap; m_wait = n_wait; m_stall = n_stall; m_flush = n_flush;
    prev_rst = rst_ni;
    bus.ex_mem_memreq_i  = memreq;
    bus.dmem_ready_i     = dready;
    bus.imem_ready_i     = iready;
    bus.ex_redirect_i    = redir;
    bus.id_ex_memread_i  = memread;
    bus.id_ex_rd_i       = rd;
    bus.if_id_rs1_i      = rs1;
    bus.if_id_rs2_i      = rs2;
    bus.if_id_rs1_used_i = u1;
    bus.if_id_rs2_used_i = u2;
    rst_ni               = rst;

    lu = memread && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (!rst) frozen = 1;
    else if (m_trap) frozen = 1;
    else if (m_wait > 0) frozen = !dready;
    else frozen = memreq && !dready;

    pc_en = 1; pc_sel = 0; ifid_en = 1; ifid_fl = 0;
    idex_en = 1; idex_fl = 0; exmem_en = 1; memwb_en = 1;
    if (frozen) begin
      pc_en = 0; ifid_en = 0; idex_en = 0; exmem_en = 0; memwb_en = 0;
    end else if (redir) begin
      pc_sel = 1; ifid_fl = 1; idex_fl = 1;
    end else if (lu) begin
      pc_en = 0; ifid_en = 0; idex_fl = 1;
    end else if (!iready) begin
      pc_en = 0; ifid_fl = 1;
    end

    e.ctl = {pc_en, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en, 1'b0};
    e.to  = rst ? m_trap : 1'b0;
    e.st  = rst ? m_stall : '0;
    e.fl  = rst ? m_flush : '0;
    sb_q.push_back(e);

    if (!rst) begin
      n_trap = 0; n_wait = 0; n_stall = '0; n_flush = '0;
    end else begin
      n_stall = m_stall + CNT_W'(!pc_en);
      n_flush = m_flush + CNT_W'(pc_sel);
      n_trap  = m_trap;
      n_wait  = m_wait;
      if (!m_trap) begin
        if (frozen) begin
          n_wait = m_wait + 1;
          if (n_wait == TO) n_trap = 1;
        end else begin
          n_wait = 0;
        end
      end
    end

    // Reset must take effect before any clock edge.
    if (prev_rst && !rst) begin
      #1;
      chk("async_rst_ctl", 64'(act_ctl()), 64'(0));
      chk("async_rst_cnt", {bus.stall_cnt_o, bus.flush_cnt_o}, 64'(0));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ctl", 64'(act_ctl()), 64'(e.ctl));
        chk("dmem_timeout", 64'(bus.dmem_timeout_o), 64'(e.to));
        chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(e.st));
        chk("flush_cnt", 64'(bus.flush_cnt_o), 64'(e.fl));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ex_mem_memreq_i = 0; bus.dmem_ready_i = 1; bus.imem_ready_i = 1;
    bus.ex_redirect_i = 0; bus.id_ex_memread_i = 0; bus.id_ex_rd_i = '0;
    bus.if_id_rs1_i = '0; bus.if_id_rs2_i = '0;
    bus.if_id_rs1_used_i = 0; bus.if_id_rs2_used_i = 0;

    cycle(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    // load-use on rs1, then rd=x0 (no stall)
    cycle(1, 0, 1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    idle(1);
    cycle(1, 0, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    // load-use on rs2 only
    cycle(1, 0, 1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 1);
    // redirect together with load-use
    cycle(1, 0, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    idle(1);
    // 3-cycle dmem wait then release
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // zero-wait access
    cycle(1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // redirect held through a freeze
    for (int i = 0; i < 2; i++) cycle(1, 1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(1, 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // imem wait
    for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // async reset in the middle of a dmem wait
    cycle(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // watchdog trap, sticky after ready, cleared by reset
    for (int i = 0; i < TO + 1; i++) cycle(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) >= 2,
            $urandom_range(99) < 30,
            $urandom_range(99) < 70,
            $urandom_range(99) < 80,
            $urandom_range(99) < 15,
            $urandom_range(99) < 40,
            5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            $urandom_range(1) == 1, $urandom_range(1) == 1);
    end

    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
